// File: rtl/window_buffer_3x3.sv
// 3x3 sliding window over a raster pixel stream using two line buffers.
// Optional frame sync input enabled by defining WINDOW_FRAME_SYNC_EN.
module window_buffer_3x3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned COL_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
`ifdef WINDOW_FRAME_SYNC_EN
  input  logic                  frame_start,
`endif
  output logic [DATA_WIDTH-1:0] win_00,
  output logic [DATA_WIDTH-1:0] win_01,
  output logic [DATA_WIDTH-1:0] win_02,
  output logic [DATA_WIDTH-1:0] win_10,
  output logic [DATA_WIDTH-1:0] win_11,
  output logic [DATA_WIDTH-1:0] win_12,
  output logic [DATA_WIDTH-1:0] win_20,
  output logic [DATA_WIDTH-1:0] win_21,
  output logic [DATA_WIDTH-1:0] win_22,
  output logic                  window_valid
);

  localparam int unsigned AddrWidth = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  logic [DATA_WIDTH-1:0] win_q [3][3];
  logic [DATA_WIDTH-1:0] win_d [3][3];
  logic [COL_WIDTH-1:0]  col_q, col_d, eff_col;
  logic [1:0]            row_q, row_d, eff_row;
  logic                  valid_q, valid_d;
  logic [AddrWidth-1:0]  addr;
  logic                  at_eol;

  always_comb begin
    eff_col = col_q;
    eff_row = row_q;
`ifdef WINDOW_FRAME_SYNC_EN
    // A frame-start pixel is placed at (0,0) regardless of the current position.
    if (frame_start) begin
      eff_col = '0;
      eff_row = '0;
    end
`endif
    addr    = eff_col[AddrWidth-1:0];
    at_eol  = (eff_col == COL_WIDTH'(IMG_WIDTH - 1));
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    if (pixel_valid) begin
      col_d = at_eol ? '0 : eff_col + 1'b1;
      row_d = (at_eol && eff_row != 2'd2) ? eff_row + 2'd1 : eff_row;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][2] = lb0[addr];
      win_d[1][2] = lb1[addr];
      win_d[2][2] = pixel_in;
      valid_d     = (eff_row == 2'd2) && (eff_col >= COL_WIDTH'(2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  // Line buffers are left unreset; row gating keeps stale data out of valid windows.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb1[addr] <= pixel_in;
      lb0[addr] <= lb1[addr];
    end
  end

  assign win_00       = win_q[0][0];
  assign win_01       = win_q[0][1];
  assign win_02       = win_q[0][2];
  assign win_10       = win_q[1][0];
  assign win_11       = win_q[1][1];
  assign win_12       = win_q[1][2];
  assign win_20       = win_q[2][0];
  assign win_21       = win_q[2][1];
  assign win_22       = win_q[2][2];
  assign window_valid = valid_q;

endmodule

// File: tb/tb_window_buffer_3x3.sv
// Scoreboard bench for window_buffer_3x3: a reference model predicts every window,
// a negedge monitor compares whenever window_valid is high and checks hold while idle.
module tb_window_buffer_3x3;

  localparam int IMGW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       frame_start;
  logic [7:0] win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22;
  logic       window_valid;

  window_buffer_3x3 #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (IMGW),
    .COL_WIDTH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
`ifdef WINDOW_FRAME_SYNC_EN
    .frame_start (frame_start),
`endif
    .win_00      (win_00),
    .win_01      (win_01),
    .win_02      (win_02),
    .win_10      (win_10),
    .win_11      (win_11),
    .win_12      (win_12),
    .win_20      (win_20),
    .win_21      (win_21),
    .win_22      (win_22),
    .window_valid(window_valid)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [71:0] exp_q[$];
  logic [7:0]  img [4][IMGW];  // last four lines, indexed by line number mod 4
  int          mr = 0;
  int          mc = 0;
  bit          last_acc = 1'b0;
  bit          have_last = 1'b0;
  logic [71:0] last_win;
  logic [71:0] dut_win;

  assign dut_win = {win_22, win_21, win_20, win_12, win_11, win_10, win_02, win_01, win_00};

  always @(posedge clk) last_acc <= pixel_valid;

  // Monitor: pops one expected window per window_valid, otherwise checks the window holds.
  always @(negedge clk) begin
    logic [71:0] e;
    if (rst) begin
      have_last = 1'b0;
    end else if (window_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_window: window_valid=1 required 0, win=%h", dut_win);
      end else begin
        e = exp_q.pop_front();
        if (dut_win !== e) begin
          miscompares++;
          $display("FAIL window: got %h required %h", dut_win, e);
        end
        last_win  = e;
        have_last = 1'b1;
      end
    end else if (last_acc) begin
      have_last = 1'b0;
    end else if (have_last) begin
      vectors++;
      if (dut_win !== last_win) begin
        miscompares++;
        $display("FAIL idle_hold: got %h required %h", dut_win, last_win);
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] px, input bit fs);
    logic [71:0] w;
    pixel_valid = v;
    pixel_in    = px;
    frame_start = fs;
    if (v) begin
`ifdef WINDOW_FRAME_SYNC_EN
      if (fs) begin
        mr = 0;
        mc = 0;
      end
`endif
      img[mr % 4][mc] = px;
      if (mr >= 2 && mc >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[8*(i*3+j) +: 8] = img[(mr - 2 + i) % 4][mc - 2 + j];
        exp_q.push_back(w);
      end
      mc++;
      if (mc == IMGW) begin
        mc = 0;
        mr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int r, input int c);
    drive(1'b1, 8'(r * 16 + c), 1'b0);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (dut_win !== 72'h0 || window_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: win=%h valid=%b required all 0", name, dut_win, window_valid);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic async_reset();
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero("async_reset");
    exp_q.delete();
    mr = 0;
    mc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    frame_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check_zero("reset_state");
    rst = 1'b0;

    // Rows 0..3 with an idle gap after 0x22.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < IMGW; c++) begin
        pix(r, c);
        if (r == 2 && c == 2) begin
          for (int k = 0; k < 3; k++) drive(1'b0, 8'hee, 1'b0);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0);

    // Reset after 0x13, then restream from 0x00.
    async_reset();
    for (int p = 0; p < 8; p++) pix(p / IMGW, p % IMGW);
    async_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < IMGW; c++) pix(r, c);
    drive(1'b0, 8'h00, 1'b0);

`ifdef WINDOW_FRAME_SYNC_EN
    // Partial frame ending at 0x21, then a frame_start restart.
    async_reset();
    for (int p = 0; p < 10; p++) pix(p / IMGW, p % IMGW);
    drive(1'b1, 8'h00, 1'b1);
    for (int p = 1; p < 3 * IMGW; p++) pix(p / IMGW, p % IMGW);
    drive(1'b0, 8'h00, 1'b0);
`endif

    // Random pixels, random gaps, occasional reset / frame start.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 39) == 0);
    end
    for (int n = 0; n < 4; n++) drive(1'b0, 8'h00, 1'b0);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_windows: %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_buffer_3x3.md
WINDOW_BUFFER_3X3 -- requirements
Module: window_buffer_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 320, pixels per line; legal range 3..1024.
REQ-003 SHALL have parameter COL_WIDTH, default 10, column counter width; ceil(log2(IMG_WIDTH)) <= COL_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port pixel_in  input  DATA_WIDTH  raster-order pixel stream.
REQ-007 SHALL have port pixel_valid  input  1  pixel_in accepted on this edge.
REQ-008 SHALL have ports win_00..win_22  output  DATA_WIDTH each  3x3 window, win_RC, R=row (0 oldest line), C=column (0 leftmost); registered.
REQ-009 SHALL have port window_valid  output  1  win_* hold a complete in-image window this cycle.

Function
REQ-010 SHALL hold two line buffers LB0 (line n-2) and LB1 (line n-1), IMG_WIDTH entries each, addressed by column counter col.
REQ-011 On accepted pixel: LB1[col] <= pixel_in, LB0[col] <= old LB1[col] (read-before-write, same edge).
REQ-012 On accepted pixel: each window row shifts left (C0<=C1, C1<=C2); new C2 = old LB0[col] (row 0), old LB1[col] (row 1), pixel_in (row 2).
REQ-013 col SHALL count 0..IMG_WIDTH-1 per accepted pixel and wrap to 0, incrementing row counter row; row saturates at 2.
REQ-014 window_valid SHALL be registered: 1 on the edge after an accepted pixel with row==2 and col>=2 at acceptance, else 0.
REQ-015 Latency: pixel (r,c) appears at win_22 and completes window centred on (r-1,c-1) one clock after acceptance.
REQ-016 pixel_valid=0 SHALL freeze col, row, line buffers and win_*; window_valid SHALL drop to 0.
REQ-017 Windows SHALL never straddle a line boundary: columns 0 and 1 of each line produce window_valid=0 (no border padding).
REQ-018 Back-to-back pixel_valid with no gaps SHALL sustain one window per clock.

Reset
REQ-019 rst SHALL asynchronously clear col, row, window_valid and all win_* to 0.
REQ-020 Line buffer contents SHALL NOT be reset; they are refilled before any window_valid (row reaches 2).
REQ-021 Reset mid-line SHALL discard the partial frame; next accepted pixel is treated as (0,0).

Configuration
REQ-022 Macro WINDOW_FRAME_SYNC_EN defined: extra port frame_start input 1; accepted pixel with frame_start=1 is taken as (0,0): col<=1, row<=0, window_valid<=0, shift/write as REQ-011/012.
REQ-023 WINDOW_FRAME_SYNC_EN undefined: no frame_start port; position resets only via rst and line wrap.
REQ-024 frame_start with pixel_valid=0 SHALL be ignored.

Verification (IMG_WIDTH=4, pixel value = row*16+col)
REQ-025 Reset, stream rows 0-2 contiguously -> window_valid first 1 the edge after pixel 0x22 accepted; win_00=0x00, win_11=0x11, win_22=0x22.
REQ-026 Continue to 0x23 -> window_valid 1 with win_00=0x01, win_22=0x23; then 0x30,0x31 -> window_valid 0; 0x32 -> valid, win_00=0x10, win_11=0x21, win_22=0x32.
REQ-027 Insert 3 idle cycles between 0x22 and 0x23 -> window_valid 0 during idle, win_* hold 0x00..0x22 window, then resume as REQ-026.
REQ-028 Assert rst asynchronously after 0x13 -> all outputs 0 immediately; restream from 0x00 -> first valid again after 0x22.
REQ-029 (WINDOW_FRAME_SYNC_EN) frame_start with pixel 0x00 after partial frame ending at 0x21 -> no valid until new 0x22; window then matches REQ-025.
